// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared types and helpers for the TDC capture controller:
//               FSM state encoding, fine-code width helper, miss counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package tdc_pkg;

  // Width of the saturating lost-hit counter
  localparam int c_MISS_W = 8;

  // Capture sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_ENCODE = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DEAD   = 3'd4
  } tdc_state_e;

  // Bits needed to hold a popcount of 0..nmux
  function automatic int fine_w(input int nmux);
    return $clog2(nmux + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_therm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tdc_therm_encoder
// Description : Combinational thermometer-to-binary encoder. Counts the set
//               taps of a latched delay line snapshot. When
//               TDC_BUBBLE_FILTER_EN is defined, interior taps are replaced
//               by a 3-tap majority vote before counting; end taps pass as-is.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_therm_encoder
  import tdc_pkg::*;
#(
  parameter int NMUX = 32,
  parameter int FW   = fine_w(NMUX)
) (
  input  logic [NMUX-1:0] i_snap,
  output logic [FW-1:0]   o_fine
);

  logic [NMUX-1:0] w_taps;

`ifdef TDC_BUBBLE_FILTER_EN
  // End taps have only one neighbour, so they are not voted
  assign w_taps[0]      = i_snap[0];
  assign w_taps[NMUX-1] = i_snap[NMUX-1];

  // Majority of each interior tap and its two neighbours removes single bubbles
  for (genvar i = 1; i < NMUX - 1; i++) begin : g_bubble_vote
    assign w_taps[i] = (i_snap[i-1] & i_snap[i])   |
                       (i_snap[i]   & i_snap[i+1]) |
                       (i_snap[i-1] & i_snap[i+1]);
  end
`else
  assign w_taps = i_snap;
`endif

  // Population count of the (optionally filtered) taps
  always_comb begin
    o_fine = '0;
    for (int i = 0; i < NMUX; i++) begin
      o_fine = o_fine + FW'(w_taps[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdc_capture_ctrl
// Description : TDC delay line capture sequencer. Double-registers the tap
//               word, detects a rising edge on tap 0, latches the snapshot
//               and coarse stamp, encodes the fine count, offers {coarse,fine}
//               on a valid/ready port, then holds off until the line has
//               flushed plus DEAD_CYCLES before re-arming.
//               Optional macro: TDC_BUBBLE_FILTER_EN (majority bubble filter
//               inside the encoder).
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_capture_ctrl
  import tdc_pkg::*;
#(
  parameter int NMUX        = 32,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic [NMUX-1:0]                   therm_in,
  output logic                              ts_valid,
  input  logic                              ts_ready,
  output logic [COARSE_W+fine_w(NMUX)-1:0]  ts_data,
  output logic                              busy,
  output logic [c_MISS_W-1:0]               miss_cnt
);

  localparam int c_FW     = fine_w(NMUX);
  localparam int c_DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  logic [NMUX-1:0]     r_s1;
  logic [NMUX-1:0]     r_s2;
  logic                r_s2_lsb_d;
  logic [COARSE_W-1:0] r_coarse;
  logic [NMUX-1:0]     r_snap;
  logic [COARSE_W-1:0] r_cstamp;
  logic [c_FW-1:0]     r_fine;
  logic [c_FW-1:0]     w_fine;
  logic                r_ts_valid;
  logic [c_MISS_W-1:0] r_miss_cnt;
  logic                r_zero_seen;
  logic [c_DCNT_W-1:0] r_dead_cnt;
  tdc_state_e          r_state;
  tdc_state_e          w_next_state;
  logic                w_hit;
  logic                w_line_zero;
  logic                w_dead_done;
  logic                w_miss_window;

  assign w_hit         = r_s2[0] & ~r_s2_lsb_d;
  assign w_line_zero   = (r_s2 == '0);
  assign w_miss_window = (r_state == ST_ENCODE) || (r_state == ST_OUTPUT) ||
                         (r_state == ST_DEAD);

  tdc_therm_encoder #(
    .NMUX (NMUX),
    .FW   (c_FW)
  ) u_encoder (
    .i_snap (r_snap),
    .o_fine (w_fine)
  );

  // Two-stage synchroniser for the asynchronous taps plus tap-0 history for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s2_lsb_d <= 1'b0;
    end else begin
      r_s1       <= therm_in;
      r_s2       <= r_s1;
      r_s2_lsb_d <= r_s2[0];
    end
  end

  // Free-running coarse counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) r_coarse <= '0;
    else     r_coarse <= r_coarse + COARSE_W'(1);
  end

  // Dead time exit: line reads zero, then DEAD_CYCLES further cycles
  always_comb begin
    w_dead_done = 1'b0;
    if (DEAD_CYCLES == 0) w_dead_done = w_line_zero;
    else                  w_dead_done = r_zero_seen && (int'(r_dead_cnt) == DEAD_CYCLES - 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and busy flag
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (arm) w_next_state = ST_ARMED;
      end
      ST_ARMED: begin
        busy = 1'b0;
        if (!arm)       w_next_state = ST_IDLE;
        else if (w_hit) w_next_state = ST_ENCODE;
      end
      ST_ENCODE: w_next_state = ST_OUTPUT;
      ST_OUTPUT: if (ts_ready) w_next_state = ST_DEAD;
      ST_DEAD:   if (w_dead_done) w_next_state = arm ? ST_ARMED : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Capture datapath: snapshot and stamp on the hit, fine code in ENCODE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= '0;
      r_cstamp   <= '0;
      r_fine     <= '0;
      r_ts_valid <= 1'b0;
    end else begin
      if (r_state == ST_ARMED && arm && w_hit) begin
        r_snap   <= r_s2;
        r_cstamp <= r_coarse;
      end
      if (r_state == ST_ENCODE) r_fine <= w_fine;
      r_ts_valid <= (w_next_state == ST_OUTPUT);
    end
  end

  // Dead time tracking: remember the flush point, then count extra idle cycles
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_DEAD) begin
      r_zero_seen <= 1'b0;
      r_dead_cnt  <= '0;
    end else if (!r_zero_seen) begin
      r_zero_seen <= w_line_zero;
      r_dead_cnt  <= '0;
    end else if (!w_dead_done) begin
      r_dead_cnt  <= r_dead_cnt + c_DCNT_W'(1);
    end
  end

  // Saturating count of hits that arrive while a capture is in flight
  always_ff @(posedge clk) begin
    if (rst)                                              r_miss_cnt <= '0;
    else if (w_hit && w_miss_window && r_miss_cnt != '1)  r_miss_cnt <= r_miss_cnt + c_MISS_W'(1);
  end

  assign ts_valid = r_ts_valid;
  assign ts_data  = {r_cstamp, r_fine};
  assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: doc/tdc_capture_ctrl.md
# tdc_capture_ctrl

Sequencing controller for the FPGA TDC delay line. It samples the `NMUX`-tap thermometer code, detects a hit on the first tap, and latches the snapshot. It encodes the fine bin count, stamps it with a free-running coarse counter, and presents the result on a valid/ready output. It then enforces dead time until the line has flushed before re-arming. It sits between the delay line outputs and the readout FIFO.

## Interface
- `NMUX`, 32, delay line tap count; matches the delay line width
- `COARSE_W`, 16, coarse counter width
- `DEAD_CYCLES`, 2, extra idle cycles after the line reads all-zero; 0 is legal
- `clk`  in  1  system clock, also the sampling clock
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  level; high permits capture
- `therm_in`  in  NMUX  raw delay line taps, asynchronous to `clk`
- `ts_valid`  out  1  timestamp valid
- `ts_ready`  in  1  downstream accept
- `ts_data`  out  COARSE_W+FW  {coarse, fine}, where FW = $clog2(NMUX+1)
- `busy`  out  1  high in every state except IDLE and ARMED
- `miss_cnt`  out  8  saturating count of hits lost while busy

## Operation
- `therm_in` is registered twice: `s1`, then `s2`. All logic uses `s2`.
- Hit event: `s2[0]==1` and the previous `s2[0]==0`.
- `coarse` is free-running, increments every cycle and wraps modulo 2^COARSE_W. Reset value is 0.
- FSM states: IDLE, ARMED, ENCODE, OUTPUT, DEAD.
  - IDLE → ARMED when `arm` is high.
  - ARMED → IDLE when `arm` is low.
  - ARMED → ENCODE on a hit event. Latch `snap<=s2` and `cstamp<=coarse` in that same cycle.
  - ENCODE, one cycle: `fine<=popcount(snap)`, range 0..NMUX. Go to OUTPUT.
  - OUTPUT: `ts_valid=1`. `ts_data={cstamp,fine}` is held stable until `ts_ready`. On handshake, go to DEAD.
  - DEAD: wait until `s2==0`, then DEAD_CYCLES further cycles, then go to ARMED if `arm` is high, else IDLE.
- If `arm` drops in ENCODE or OUTPUT, the pending timestamp still completes.
- `miss_cnt` increments on every hit event seen in ENCODE, OUTPUT or DEAD. It saturates at 255 and is cleared only by `rst`.
- Fine convention: a larger `fine` means the hit arrived earlier relative to the sampling edge. Downstream logic converts this.

## Timing
- Reset values:
  - FSM = IDLE
  - `ts_valid=0`, `ts_data=0`, `busy=0`, `miss_cnt=0`
  - `s1`/`s2`/`snap`/`cstamp`/`fine` = 0
  - `coarse=0`
- Latency: the hit event is in cycle N (`s2` view). ENCODE runs in N+1. `ts_valid` rises in N+2 and is registered.
- Back-pressure: with `ts_ready` held low, OUTPUT holds indefinitely. Hits arriving meanwhile are counted in `miss_cnt`, not captured.
- Minimum spacing between two captured hits: 3 + (cycles for the line to read zero) + DEAD_CYCLES.
- Coarse wrap: `cstamp` is the raw value. A timestamp taken at coarse=2^COARSE_W−1 followed by one at 0 is legal, and downstream unwraps it.
- `rst` mid-operation: the pending timestamp is discarded, `ts_valid` falls the next cycle, and all state returns to its reset value.
- A hit in the same cycle that `arm` rises (state IDLE) is ignored. It is not counted as a miss.

## Configuration
- `TDC_BUBBLE_FILTER_EN` defined:
  - Before popcount, each tap i in 1..NMUX−2 is replaced by the majority of `snap[i-1:i+1]`.
  - Tap 0 and tap NMUX−1 pass unchanged.
  - Latency is unchanged; the filter is part of ENCODE.
- Not defined: raw popcount of `snap`.

## Structure
- Shared package `tdc_pkg`:
  - FSM state enum
  - function `fine_w(nmux)` returning $clog2(nmux+1)
  - miss counter width constant (8)
- One natural sub-module: `tdc_therm_encoder`. It is combinational, takes `snap`, and returns `fine`. It contains the optional bubble filter.

## Test plan
- Reset, then `arm=1`, `ts_ready=1`, and a `therm_in` snapshot of the 20 low taps set, held. Required: `ts_valid` for exactly one cycle, 2 cycles after the `s2` hit event, with fine=20 and coarse equal to the counter value at the hit event.
- `ts_ready=0` for 10 cycles after a capture, with 3 further hit events injected. Required: `ts_data` stable throughout, `miss_cnt=3`, and capture resumes after the handshake plus dead time.
- Coarse wrap, COARSE_W=4: hits at coarse=15, then after rearm at coarse=1 (wrapped). Required: `cstamp` values 15 and 1.
- Bubble pattern 0x000F_F7FF (bit 11 cleared). Required: fine=20 with `TDC_BUBBLE_FILTER_EN` defined, fine=19 without.
- `rst` asserted while in OUTPUT. Required: `ts_valid` 0 the next cycle, FSM IDLE, `miss_cnt` 0.
- `arm` low throughout while a hit is applied. Required: no `ts_valid`, `miss_cnt` unchanged at 0.
